// File: rtl/control_store_reader_if.sv
// control_store_reader_if
//   Bundles the instruction handshake, control store port and control word
//   output of control_store_reader.
//   slave  : the reader (receives inst/cs_bits/cw_ready, drives the rest)
//   master : the environment around it (instruction source, control store
//            ROM, downstream consumer)
//   Signals:
//     inst[15:0], inst_valid, inst_ready  instruction handshake
//     flush                               discard in-flight/buffered words
//     cs_addr[5:0], cs_bits[22:0]         control store read port
//     cw[22:0], cw_inst[15:0], cw_valid,
//     cw_ready                            control word output handshake
//     cw_illegal                          only with CS_ILLEGAL_TRAP_EN defined
interface control_store_reader_if;
    logic [15:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        flush;
    logic [5:0]  cs_addr;
    logic [22:0] cs_bits;
    logic [22:0] cw;
    logic [15:0] cw_inst;
    logic        cw_valid;
    logic        cw_ready;
`ifdef CS_ILLEGAL_TRAP_EN
    logic        cw_illegal;

    modport slave (
        input  inst, inst_valid, flush, cs_bits, cw_ready,
        output inst_ready, cs_addr, cw, cw_inst, cw_valid, cw_illegal
    );
    modport master (
        output inst, inst_valid, flush, cs_bits, cw_ready,
        input  inst_ready, cs_addr, cw, cw_inst, cw_valid, cw_illegal
    );
`else
    modport slave (
        input  inst, inst_valid, flush, cs_bits, cw_ready,
        output inst_ready, cs_addr, cw, cw_inst, cw_valid
    );
    modport master (
        output inst, inst_valid, flush, cs_bits, cw_ready,
        input  inst_ready, cs_addr, cw, cw_inst, cw_valid
    );
`endif
endinterface

// File: rtl/control_store_reader.sv
// control_store_reader
//   Decodes a 16-bit instruction into a control store address, waits one
//   cycle for the synchronous control store to return the word, and queues
//   {control word, instruction} pairs in a 3-entry FIFO for downstream.
//   Optional feature macro: CS_ILLEGAL_TRAP_EN -- adds cw_illegal, flagging
//   an all-zero control word at the FIFO head.
//   Ports:
//     clk    : clock, rising edge
//     rst_n  : synchronous active-low reset
//     bus    : control_store_reader_if.slave (instruction handshake, flush,
//              control store port, control word output)
module control_store_reader (
    input  logic                         clk,
    input  logic                         rst_n,
    control_store_reader_if.slave        bus
);
    localparam int DEPTH = 3;

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        PARTIAL = 2'd1,
        FULL    = 2'd2
    } fifo_state_e;

    typedef struct packed {
        logic [22:0] cw;
        logic [15:0] inst;
    } entry_t;

    fifo_state_e state_q, state_d;
    logic        s1_valid_q, s1_valid_d;
    logic [15:0] s1_inst_q, s1_inst_d;
    logic [1:0]  count_q, count_d;
    logic [1:0]  wr_ptr_q, wr_ptr_d;
    logic [1:0]  rd_ptr_q, rd_ptr_d;
    entry_t      mem_q [DEPTH];
    entry_t      mem_d [DEPTH];

    logic        accept;
    logic        push;
    logic        pop;
    logic        cw_valid;
    logic [2:0]  occupancy;
    entry_t      head;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Address decode is purely combinational off inst; the control store
    // samples it on the accepting edge.
    assign bus.cs_addr = {bus.inst[15:12], bus.inst[11], bus.inst[5]};

    // Count the word in flight through the control store as occupied, so a
    // push never needs a room check. rst_n is folded in so inst_ready is
    // low for the whole reset cycle, not just after the reset edge.
    assign occupancy      = {1'b0, count_q} + {2'b0, s1_valid_q};
    assign bus.inst_ready = rst_n & ~bus.flush & (occupancy < 3'd3);

    assign accept = bus.inst_valid & bus.inst_ready;
    assign push   = s1_valid_q;
    assign pop    = cw_valid & bus.cw_ready;

    // Datapath next-state: stage 1 register, FIFO storage, pointers, count.
    always_comb begin
        s1_valid_d = accept;
        s1_inst_d  = accept ? bus.inst : s1_inst_q;
        count_d    = count_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];

        if (bus.flush) begin
            // flush wins over any push/pop on the same edge
            s1_valid_d = 1'b0;
            count_d    = 2'd0;
            wr_ptr_d   = 2'd0;
            rd_ptr_d   = 2'd0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = {bus.cs_bits, s1_inst_q};
                wr_ptr_d        = ptr_inc(wr_ptr_q);
            end
            if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
            case ({push, pop})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid_q <= 1'b0;
            s1_inst_q  <= '0;
            count_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inst_q  <= s1_inst_d;
            count_q    <= count_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
        end
    end

    // FIFO occupancy FSM: state register
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= EMPTY;
        else        state_q <= state_d;
    end

    // FIFO occupancy FSM: next state. Pop only happens when non-empty, and
    // push into FULL is prevented by inst_ready.
    always_comb begin
        state_d = state_q;
        if (bus.flush) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY:   if (push) state_d = PARTIAL;
                PARTIAL: begin
                    if (push && !pop && count_q == 2'd2)      state_d = FULL;
                    else if (pop && !push && count_q == 2'd1) state_d = EMPTY;
                end
                FULL:    if (pop && !push) state_d = PARTIAL;
                default: state_d = EMPTY;
            endcase
        end
    end

    // FIFO occupancy FSM: outputs. Head data is zeroed when nothing valid.
    always_comb begin
        cw_valid    = rst_n & (state_q != EMPTY);
        head        = cw_valid ? mem_q[rd_ptr_q] : '0;
        bus.cw_valid = cw_valid;
        bus.cw       = head.cw;
        bus.cw_inst  = head.inst;
`ifdef CS_ILLEGAL_TRAP_EN
        bus.cw_illegal = cw_valid & (head.cw == 23'b0);
`endif
    end

endmodule
